// File: rtl/fport_control_parser_pkg.sv
// Shared constants, parser state encoding and the one's-complement adder
// used by the FPort control-frame parser.
package fport_control_parser_pkg;

    localparam logic [7:0] FPORT_DELIM         = 8'h7E;
    localparam logic [7:0] FPORT_ESC           = 8'h7D;
    localparam logic [7:0] FPORT_XOR           = 8'h20;
    localparam logic [7:0] FPORT_CTRL_LEN      = 8'h19;
    localparam logic [7:0] FPORT_TYPE_CTRL     = 8'h00;
    localparam int         FPORT_PAYLOAD_BYTES = 22;
    localparam int         FPORT_FLAG_FAILSAFE = 3;
    localparam int         NUM_CH              = 16;
    localparam int         CH_W                = 11;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_TYPE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_FLAGS   = 3'd4,
        ST_RSSI    = 3'd5,
        ST_CRC     = 3'd6
    } state_t;

    // 8-bit add with the carry folded back into bit 0 (FPort checksum)
    function automatic logic [7:0] eac_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7:0] + {7'd0, s[8]};
    endfunction

endpackage

// File: rtl/fport_byte_unstuff.sv
// Removes FPort byte stuffing. Classification is combinational on the
// incoming byte; only the escape flag is registered, so no latency is added.
module fport_byte_unstuff
    import fport_control_parser_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       d_valid,
    output logic [7:0] d_byte,
    output logic       d_delim,
    output logic       d_abort
);

    logic esc;
    logic v;
    logic is_delim;
    logic is_esc;

    // bytes offered during reset are dropped
    assign v        = rx_valid & ~reset;
    assign is_delim = (rx_byte == FPORT_DELIM);
    assign is_esc   = (rx_byte == FPORT_ESC);

    // an escaped 0x7D is treated as data (0x5D), only a fresh 0x7D starts an escape
    assign d_delim = v & is_delim & ~esc;
    assign d_abort = v & is_delim & esc;
    assign d_valid = v & ~is_delim & (esc | ~is_esc);
    assign d_byte  = esc ? (rx_byte ^ FPORT_XOR) : rx_byte;

    // escape flag: armed by a bare 0x7D, consumed by whatever byte follows
    always_ff @(posedge clock) begin
        if (reset)  esc <= 1'b0;
        else if (v) esc <= ~esc & is_esc;
    end

endmodule

// File: rtl/fport_control_parser.sv
// FPort control-frame parser: unstuffs the UART byte stream, walks the
// frame layout, checks the additive CRC and publishes an atomic channel
// snapshot. Also runs the link-loss failsafe timer and error counters.
module fport_control_parser
    import fport_control_parser_pkg::*;
#(
    parameter int FAILSAFE_CLKS = 1_600_000,
    parameter int CNT_W         = 8
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_byte,
    output logic [NUM_CH*CH_W-1:0] channels,
    output logic [7:0]             flags,
    output logic [7:0]             rssi,
    output logic                   frame_valid,
    output logic                   failsafe,
    output logic [CNT_W-1:0]       crc_err_cnt,
    output logic [CNT_W-1:0]       frame_err_cnt
);

    localparam int                TMR_W  = $clog2(FAILSAFE_CLKS + 1);
    localparam logic [TMR_W-1:0]  FS_MAX = TMR_W'(FAILSAFE_CLKS);

    logic       d_valid, d_delim, d_abort;
    logic [7:0] d_byte;

    state_t     state, state_d;
    logic [4:0] idx;
    logic       last_idx;
    logic [7:0] sum, sum_nx;
    logic [7:0] tmp_flags, tmp_rssi;
    logic [FPORT_PAYLOAD_BYTES-1:0][7:0] pay_buf;
    logic [FPORT_PAYLOAD_BYTES-1:0][7:0] ch_bytes;
    logic [TMR_W-1:0] fs_cnt;

    logic sum_init, sum_acc, idx_clr, buf_we, flags_we, rssi_we;
    logic crc_ok, crc_bad, ferr_inc;

    fport_byte_unstuff u_unstuff (
        .clock    (clock),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .d_valid  (d_valid),
        .d_byte   (d_byte),
        .d_delim  (d_delim),
        .d_abort  (d_abort)
    );

    assign sum_nx   = eac_add(sum, d_byte);
    assign last_idx = (idx == 5'(FPORT_PAYLOAD_BYTES - 1));

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= ST_HUNT;
        else       state <= state_d;
    end

    // next state: any delimiter (clean or aborting) restarts at the length byte
    always_comb begin
        state_d = state;
        if (d_abort || d_delim) begin
            state_d = ST_LEN;
        end else if (d_valid) begin
            case (state)
                ST_LEN:     state_d = (d_byte == FPORT_CTRL_LEN)  ? ST_TYPE    : ST_HUNT;
                ST_TYPE:    state_d = (d_byte == FPORT_TYPE_CTRL) ? ST_PAYLOAD : ST_HUNT;
                ST_PAYLOAD: state_d = last_idx ? ST_FLAGS : ST_PAYLOAD;
                ST_FLAGS:   state_d = ST_RSSI;
                ST_RSSI:    state_d = ST_CRC;
                ST_CRC:     state_d = ST_HUNT;
                default:    state_d = state;
            endcase
        end
    end

    // datapath strobes decoded from state and the current unstuffed byte
    always_comb begin
        sum_init = 1'b0;
        sum_acc  = 1'b0;
        idx_clr  = 1'b0;
        buf_we   = 1'b0;
        flags_we = 1'b0;
        rssi_we  = 1'b0;
        crc_ok   = 1'b0;
        crc_bad  = 1'b0;
        ferr_inc = d_abort | (d_delim & (state != ST_HUNT) & (state != ST_LEN));
        if (d_valid) begin
            case (state)
                ST_LEN: begin
                    if (d_byte == FPORT_CTRL_LEN) sum_init = 1'b1;
                    else                          ferr_inc = 1'b1;
                end
                ST_TYPE: begin
                    sum_acc = 1'b1;
                    idx_clr = 1'b1;
                end
                ST_PAYLOAD: begin
                    sum_acc = 1'b1;
                    buf_we  = 1'b1;
                end
                ST_FLAGS: begin
                    sum_acc  = 1'b1;
                    flags_we = 1'b1;
                end
                ST_RSSI: begin
                    sum_acc = 1'b1;
                    rssi_we = 1'b1;
                end
                ST_CRC: begin
                    crc_ok  = (sum_nx == 8'hFF);
                    crc_bad = (sum_nx != 8'hFF);
                end
                default: ;
            endcase
        end
    end

    // running checksum, payload index and the pending flags/rssi
    always_ff @(posedge clock) begin
        if (reset) begin
            sum       <= '0;
            idx       <= '0;
            tmp_flags <= '0;
            tmp_rssi  <= '0;
        end else begin
            if (sum_init)     sum <= FPORT_CTRL_LEN;
            else if (sum_acc) sum <= sum_nx;
            if (idx_clr)      idx <= '0;
            else if (buf_we)  idx <= idx + 5'd1;
            if (flags_we)     tmp_flags <= d_byte;
            if (rssi_we)      tmp_rssi  <= d_byte;
        end
    end

    // payload staging buffer; never visible until a frame passes its CRC
    always_ff @(posedge clock) begin
        if (buf_we) pay_buf[idx] <= d_byte;
    end

    // commit the staged frame as one snapshot
    always_ff @(posedge clock) begin
        if (reset) begin
            ch_bytes    <= '0;
            flags       <= '0;
            rssi        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= crc_ok;
            if (crc_ok) begin
                ch_bytes <= pay_buf;
                flags    <= tmp_flags;
                rssi     <= tmp_rssi;
            end
        end
    end

    // 11-bit channels are a little-endian bit stream over the payload bytes
    assign channels = ch_bytes;

    // saturating error counters
    always_ff @(posedge clock) begin
        if (reset) begin
            crc_err_cnt   <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (crc_bad && crc_err_cnt != '1)    crc_err_cnt   <= crc_err_cnt + CNT_W'(1);
            if (ferr_inc && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + CNT_W'(1);
        end
    end

    // link-loss timer; starts expired so failsafe holds until the first good frame
    always_ff @(posedge clock) begin
        if (reset)                 fs_cnt <= FS_MAX;
        else if (crc_ok)           fs_cnt <= '0;
        else if (fs_cnt != FS_MAX) fs_cnt <= fs_cnt + TMR_W'(1);
    end

    assign failsafe = (fs_cnt == FS_MAX) | flags[FPORT_FLAG_FAILSAFE];

endmodule

// File: tb/tb_fport_control_parser.sv
// Bench for fport_control_parser: directed frame table, hand sequences for
// failsafe timeout / reset mid-frame / counter saturation, then random
// traffic checked every cycle against a frame-level reference model.
module tb_fport_control_parser;

    localparam int FS = 300;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [175:0]  channels;
    logic [7:0]    flags, rssi;
    logic          frame_valid, failsafe;
    logic [CW-1:0] crc_err_cnt, frame_err_cnt;

    fport_control_parser #(.FAILSAFE_CLKS(FS), .CNT_W(CW)) dut (
        .clock         (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .channels      (channels),
        .flags         (flags),
        .rssi          (rssi),
        .frame_valid   (frame_valid),
        .failsafe      (failsafe),
        .crc_err_cnt   (crc_err_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // reference model state: frame-level view of the stream
    logic [175:0] m_ch;
    logic [7:0]   m_flags, m_rssi;
    logic         m_fv;
    int           m_crc, m_ferr;
    bit           m_in, m_esc;
    logic [7:0]   m_q[$];
    longint       m_last;

    bit         seen_fv;
    logic [7:0] txq[$];

    typedef struct {
        string      name;
        int         trunc;
        logic [7:0] b0, b1, fl, rs, crc;
        logic       exp_fv;
        logic [10:0] exp_ch0, exp_ch1;
        logic [7:0] exp_flags, exp_rssi;
        logic       exp_fs;
        int         exp_crc, exp_ferr;
    } vec_t;

    vec_t tv[7];

    task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [7:0] ones_sum(input logic [7:0] q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        while (s > 255) s = (s & 255) + (s >> 8);
        return 8'(s);
    endfunction

    task automatic model_reset();
        m_ch = '0; m_flags = '0; m_rssi = '0; m_fv = 1'b0;
        m_crc = 0; m_ferr = 0; m_in = 1'b0; m_esc = 1'b0;
        m_q.delete();
        m_last = -64'sd1000000;
    endtask

    // frame bytes collected after a delimiter: [0]=len [1]=type [2..23]=payload
    // [24]=flags [25]=rssi [26]=crc; judged when the frame is complete
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] d;
        if (b == 8'h7E) begin
            if (m_esc || (m_in && m_q.size() > 0)) m_ferr++;
            m_esc = 1'b0; m_in = 1'b1; m_q.delete();
        end else if (!m_esc && b == 8'h7D) begin
            m_esc = 1'b1;
        end else begin
            d = m_esc ? (b ^ 8'h20) : b;
            m_esc = 1'b0;
            if (m_in) begin
                m_q.push_back(d);
                if (m_q.size() == 1 && d != 8'h19) begin
                    m_ferr++; m_in = 1'b0;
                end else if (m_q.size() == 2 && d != 8'h00) begin
                    m_in = 1'b0;
                end else if (m_q.size() == 27) begin
                    if (ones_sum(m_q) == 8'hFF) begin
                        for (int i = 0; i < 22; i++) m_ch[8*i +: 8] = m_q[2+i];
                        m_flags = m_q[24]; m_rssi = m_q[25]; m_fv = 1'b1; m_last = cyc;
                    end else begin
                        m_crc++;
                    end
                    m_in = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic exp_fs;
        exp_fs = m_flags[3] | ((cyc - m_last) >= FS);
        chk("channels", channels, m_ch);
        chk("flags", 176'(flags), 176'(m_flags));
        chk("rssi", 176'(rssi), 176'(m_rssi));
        chk("frame_valid", 176'(frame_valid), 176'(m_fv));
        chk("failsafe", 176'(failsafe), 176'(exp_fs));
        chk("crc_err_cnt", 176'(crc_err_cnt), 176'(sat(m_crc)));
        chk("frame_err_cnt", 176'(frame_err_cnt), 176'(sat(m_ferr)));
    endtask

    // one clock: drive at negedge, sample #1 after the rising edge
    task automatic cycle(input logic rst, input logic v, input logic [7:0] b);
        @(negedge clk);
        reset = rst; rx_valid = v; rx_byte = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        m_fv = 1'b0;
        if (rst)    model_reset();
        else if (v) model_byte(b);
        if (frame_valid) seen_fv = 1'b1;
        compare_all();
    endtask

    task automatic push_st(input logic [7:0] b);
        if (b == 8'h7E || b == 8'h7D) begin
            txq.push_back(8'h7D);
            txq.push_back(b ^ 8'h20);
        end else begin
            txq.push_back(b);
        end
    endtask

    task automatic build_frame(input logic [7:0] b0, b1, fl, rs, crc);
        txq.push_back(8'h7E);
        push_st(8'h19); push_st(8'h00); push_st(b0); push_st(b1);
        repeat (20) push_st(8'h00);
        push_st(fl); push_st(rs); push_st(crc);
    endtask

    task automatic send_txq(input int gap, input bit rnd);
        foreach (txq[i]) begin
            cycle(1'b0, 1'b1, txq[i]);
            repeat (rnd ? $urandom_range(0, gap) : gap) cycle(1'b0, 1'b0, 8'h00);
        end
        txq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[22];
        logic [7:0] q[$];
        logic [7:0] fl, rs, crc, lb, tb;
        int kind, len;

        tv[0] = '{"good",     0, 8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B, 1'b1, 11'h7FF, 11'h000, 8'h00, 8'h64, 1'b0, 0, 0};
        tv[1] = '{"stuffed",  0, 8'hFF, 8'h07, 8'h00, 8'h7E, 8'h61, 1'b1, 11'h7FF, 11'h000, 8'h00, 8'h7E, 1'b0, 0, 0};
        tv[2] = '{"bad_crc",  0, 8'hFF, 8'h07, 8'h00, 8'h64, 8'h7C, 1'b0, 11'h7FF, 11'h000, 8'h00, 8'h7E, 1'b0, 1, 0};
        tv[3] = '{"resync",  10, 8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B, 1'b1, 11'h7FF, 11'h000, 8'h00, 8'h64, 1'b0, 1, 1};
        tv[4] = '{"fs_flag",  0, 8'hFF, 8'h07, 8'h08, 8'h64, 8'h73, 1'b1, 11'h7FF, 11'h000, 8'h08, 8'h64, 1'b1, 1, 1};
        tv[5] = '{"fs_clear", 0, 8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B, 1'b1, 11'h7FF, 11'h000, 8'h00, 8'h64, 1'b0, 1, 1};
        tv[6] = '{"ch_mix",   0, 8'h34, 8'h12, 8'h00, 8'h64, 8'h3C, 1'b1, 11'h234, 11'h002, 8'h00, 8'h64, 1'b0, 1, 1};

        // reset with rx_valid held high: bytes must be ignored
        repeat (3) cycle(1'b1, 1'b1, 8'h7E);
        cycle(1'b0, 1'b0, 8'h00);
        chk("rst_channels", channels, 176'd0);
        chk("rst_failsafe", 176'(failsafe), 176'd1);
        chk("rst_frame_valid", 176'(frame_valid), 176'd0);
        chk("rst_counters", 176'({crc_err_cnt, frame_err_cnt}), 176'd0);

        // directed frame table
        for (int i = 0; i < 7; i++) begin
            seen_fv = 1'b0;
            if (tv[i].trunc > 0) begin
                txq.push_back(8'h7E); push_st(8'h19); push_st(8'h00);
                repeat (tv[i].trunc) push_st(8'h11);
            end
            build_frame(tv[i].b0, tv[i].b1, tv[i].fl, tv[i].rs, tv[i].crc);
            txq.push_back(8'h7E);
            send_txq(1, 1'b0);
            chk({tv[i].name, "_fv"},    176'(seen_fv), 176'(tv[i].exp_fv));
            chk({tv[i].name, "_ch0"},   176'(channels[10:0]), 176'(tv[i].exp_ch0));
            chk({tv[i].name, "_ch1"},   176'(channels[21:11]), 176'(tv[i].exp_ch1));
            chk({tv[i].name, "_ch_hi"}, 176'(channels[175:22]), 176'd0);
            chk({tv[i].name, "_flags"}, 176'(flags), 176'(tv[i].exp_flags));
            chk({tv[i].name, "_rssi"},  176'(rssi), 176'(tv[i].exp_rssi));
            chk({tv[i].name, "_fs"},    176'(failsafe), 176'(tv[i].exp_fs));
            chk({tv[i].name, "_crc"},   176'(crc_err_cnt), 176'(tv[i].exp_crc));
            chk({tv[i].name, "_ferr"},  176'(frame_err_cnt), 176'(tv[i].exp_ferr));
        end

        // failsafe timeout boundary, back-to-back bytes
        build_frame(8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B);
        send_txq(0, 1'b0);
        repeat (FS - 1) cycle(1'b0, 1'b0, 8'h00);
        chk("fs_before_timeout", 176'(failsafe), 176'd0);
        cycle(1'b0, 1'b0, 8'h00);
        chk("fs_at_timeout", 176'(failsafe), 176'd1);
        build_frame(8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B);
        send_txq(0, 1'b0);
        chk("fs_recover_fv", 176'(frame_valid), 176'd1);
        chk("fs_recover", 176'(failsafe), 176'd0);

        // random traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                kind = $urandom_range(0, 3);
                cycle(1'b0, 1'b1, (kind == 0) ? 8'h7D : (kind == 1) ? 8'h7E : 8'($urandom));
            end
            foreach (pl[i]) pl[i] = 8'($urandom);
            fl = 8'($urandom);
            if ($urandom_range(0, 7) != 0) fl[3] = 1'b0;
            rs = 8'($urandom);
            q.delete();
            q.push_back(8'h19); q.push_back(8'h00);
            foreach (pl[i]) q.push_back(pl[i]);
            q.push_back(fl); q.push_back(rs);
            crc = 8'hFF - ones_sum(q);
            kind = $urandom_range(0, 9);
            lb = 8'($urandom);
            if (lb == 8'h19) lb = 8'h18;
            tb = 8'($urandom_range(1, 255));
            txq.push_back(8'h7E);
            push_st((kind == 9) ? lb : 8'h19);
            push_st((kind == 8) ? tb : 8'h00);
            foreach (pl[i]) push_st(pl[i]);
            push_st(fl); push_st(rs);
            push_st((kind == 6) ? (crc ^ (8'h01 << $urandom_range(0, 7))) : crc);
            if (kind == 7) begin
                len = $urandom_range(2, txq.size() - 2);
                while (txq.size() > len) void'(txq.pop_back());
            end
            send_txq(3, 1'b1);
        end

        // reset in the middle of a frame
        build_frame(8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, txq[i]);
        for (int i = 0; i < 8; i++) void'(txq.pop_front());
        repeat (2) cycle(1'b1, 1'b1, 8'($urandom));
        cycle(1'b0, 1'b0, 8'h00);
        chk("midrst_channels", channels, 176'd0);
        chk("midrst_flags_rssi", 176'({flags, rssi}), 176'd0);
        chk("midrst_failsafe", 176'(failsafe), 176'd1);
        chk("midrst_counters", 176'({crc_err_cnt, frame_err_cnt}), 176'd0);
        seen_fv = 1'b0;
        send_txq(1, 1'b0);
        chk("midrst_tail_no_commit", 176'(seen_fv), 176'd0);
        build_frame(8'hFF, 8'h07, 8'h00, 8'h64, 8'h7B);
        send_txq(1, 1'b0);
        chk("midrst_fresh_commit", 176'(seen_fv), 176'd1);
        chk("midrst_fresh_ch0", 176'(channels[10:0]), 176'h7FF);

        // saturating counters
        repeat (20) begin
            cycle(1'b0, 1'b1, 8'h7E);
            cycle(1'b0, 1'b1, 8'h55);
        end
        chk("ferr_saturate", 176'(frame_err_cnt), 176'(CMAX));
        repeat (18) begin
            build_frame(8'hFF, 8'h07, 8'h00, 8'h64, 8'h7C);
            send_txq(0, 1'b0);
        end
        chk("crc_saturate", 176'(crc_err_cnt), 176'(CMAX));
        chk("crc_sat_ferr_hold", 176'(frame_err_cnt), 176'(CMAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
